// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic-array
// write-back path.
package systolic_pkg;

    localparam int DEF_ARRAY_SIZE = 16;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int SRAM_AW        = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_row_fifo.sv
// Small synchronous row FIFO with a combinational head output.
// A push into a full FIFO is only taken when a pop frees a slot.
module wb_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/systolic_writeback.sv
// Captures quantized accumulator rows from the array controller and
// streams them to the output SRAM through a small decoupling FIFO.
module systolic_writeback
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tpu_start,
    input  logic                            tpu_done,
    input  logic                            wr_en,
    input  logic [5:0]                      matrix_index,
    input  logic [1:0]                      data_set,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] row_data,
    input  logic [4:0]                      shift,
    output logic                            sram_wr_req,
    input  logic                            sram_wr_ready,
    output logic [SRAM_AW-1:0]              sram_addr,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
    output logic [7:0]                      rows_written,
    output logic                            overflow,
    output logic                            sat_flag,
    output logic                            wb_done
);

    localparam int RW = ARRAY_SIZE * OUT_WIDTH;
    localparam int EW = SRAM_AW + RW;
    localparam logic signed [ACC_WIDTH:0] QMAX =
        (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] QMIN =
        (ACC_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

    wb_state_t               state;
    logic                    cap_en;
    logic                    cap_valid;
    logic [SRAM_AW-1:0]      cap_addr;
    logic [RW-1:0]           cap_data;
    logic [SRAM_AW-1:0]      in_addr;
    logic [RW-1:0]           q_row;
    logic [ARRAY_SIZE-1:0]   sat_vec;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic [EW-1:0]           head;

    assign cap_en  = wr_en && (state == RUN || state == DRAIN);
    assign in_addr = SRAM_AW'(data_set) * SRAM_AW'(ARRAY_SIZE)
                   + SRAM_AW'(matrix_index);

    // Rounding add is done one bit wider so it cannot wrap.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_quant
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] sum;
        logic signed [ACC_WIDTH:0] r;
        logic [OUT_WIDTH-1:0]      q;
        logic                      sat;

        always_comb begin
            ext = {row_data[i*ACC_WIDTH + ACC_WIDTH - 1],
                   row_data[i*ACC_WIDTH +: ACC_WIDTH]};
            rnd = (shift == 5'd0) ? '0
                : ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
            sum = ext + rnd;
            r   = sum >>> shift;
            q   = r[OUT_WIDTH-1:0];
            sat = 1'b0;
            if (r > QMAX) begin
                q   = QMAX[OUT_WIDTH-1:0];
                sat = 1'b1;
            end else if (r < QMIN) begin
                q   = QMIN[OUT_WIDTH-1:0];
                sat = 1'b1;
            end
        end

        assign q_row[i*OUT_WIDTH +: OUT_WIDTH] = q;
        assign sat_vec[i] = sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= '0;
        end else begin
            cap_valid <= cap_en;
            if (cap_en) begin
                cap_addr <= in_addr;
                cap_data <= q_row;
            end
        end
    end

    wb_row_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_valid),
        .din   ({cap_addr, cap_data}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Head fields are masked while empty so stale entries never leak out.
    assign pop         = !fifo_empty && sram_wr_ready;
    assign sram_wr_req = !fifo_empty;
    assign sram_addr   = fifo_empty ? '0 : head[EW-1 -: SRAM_AW];
    assign sram_wdata  = fifo_empty ? '0 : head[RW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wb_done      <= 1'b0;
            rows_written <= '0;
            overflow     <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tpu_start)
                        state <= RUN;
                end
                RUN: begin
                    if (tpu_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!cap_valid && !cap_en && fifo_empty) begin
                        state   <= DONE;
                        wb_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state == IDLE && tpu_start) begin
                rows_written <= '0;
                overflow     <= 1'b0;
                sat_flag     <= 1'b0;
            end else begin
                if (pop && rows_written != 8'hFF)
                    rows_written <= rows_written + 8'd1;
                if (cap_valid && fifo_full && !pop)
                    overflow <= 1'b1;
                if (cap_en && |sat_vec)
                    sat_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed scoreboard bench for systolic_writeback.
// Expected rows are queued when driven and checked on SRAM accept.
module tb_systolic_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         tpu_start;
    logic         tpu_done;
    logic         wr_en;
    logic [5:0]   matrix_index;
    logic [1:0]   data_set;
    logic [511:0] row_data;
    logic [4:0]   shift;
    logic         sram_wr_req;
    logic         sram_wr_ready;
    logic [6:0]   sram_addr;
    logic [127:0] sram_wdata;
    logic [7:0]   rows_written;
    logic         overflow;
    logic         sat_flag;
    logic         wb_done;

    typedef struct packed {
        logic [6:0]   a;
        logic [127:0] d;
    } exp_t;

    exp_t         exp_q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           n_writes = 0;
    int           cyc      = 0;
    int           acc_cyc  = 0;
    int           done_cyc = 0;
    bit           prev_stall = 0;
    logic [6:0]   prev_addr;
    logic [127:0] prev_data;

    systolic_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .tpu_start     (tpu_start),
        .tpu_done      (tpu_done),
        .wr_en         (wr_en),
        .matrix_index  (matrix_index),
        .data_set      (data_set),
        .row_data      (row_data),
        .shift         (shift),
        .sram_wr_req   (sram_wr_req),
        .sram_wr_ready (sram_wr_ready),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .rows_written  (rows_written),
        .overflow      (overflow),
        .sat_flag      (sat_flag),
        .wb_done       (wb_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int elem(input int r, input int i);
        return r * 3 - 50 + i;
    endfunction

    function automatic logic [511:0] mkrow(input int r);
        logic [511:0] v;
        for (int i = 0; i < 16; i++)
            v[i*32 +: 32] = 32'(elem(r, i));
        return v;
    endfunction

    function automatic logic [7:0] qm(input int acc, input int sh);
        longint v;
        v = acc;
        if (sh > 0)
            v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127)
            v = 127;
        if (v < -128)
            v = -128;
        return v[7:0];
    endfunction

    function automatic logic [127:0] mkexp(input int r, input int sh);
        logic [127:0] v;
        for (int i = 0; i < 16; i++)
            v[i*8 +: 8] = qm(elem(r, i), sh);
        return v;
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_req", 160'(sram_wr_req), 160'(1));
                chk("stall_addr", 160'(sram_addr), 160'(prev_addr));
                chk("stall_data", 160'(sram_wdata), 160'(prev_data));
            end
            if (sram_wr_req && sram_wr_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_write observed=%0h expected=none",
                           sram_addr);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 160'(sram_addr), 160'(e.a));
                    chk("wr_data", 160'(sram_wdata), 160'(e.d));
                end
                n_writes++;
                acc_cyc = cyc;
            end
            prev_stall = sram_wr_req && !sram_wr_ready;
            prev_addr  = sram_addr;
            prev_data  = sram_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_run();
        tpu_start = 1'b1;
        tick();
        tpu_start = 1'b0;
    endtask

    task automatic send_row(input int r, input int sh, input bit expect_wr,
                            input bit done);
        exp_t e;
        wr_en        = 1'b1;
        data_set     = 2'(r / 16);
        matrix_index = 6'(r % 16);
        row_data     = mkrow(r);
        tpu_done     = done;
        if (expect_wr) begin
            e.a = 7'(r);
            e.d = mkexp(r, sh);
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        tpu_done = 1'b0;
    endtask

    task automatic finish_run();
        tpu_done = 1'b1;
        tick();
        tpu_done = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        done_cyc = cyc;
        chk("wb_done_seen", 160'(seen), 160'(1));
        @(negedge clk);
        chk("wb_done_pulse", 160'(wb_done), 160'(0));
        tick();
    endtask

    initial begin
        int w0;
        exp_t e;
        rst = 1'b1;
        tpu_start = 1'b0;
        tpu_done = 1'b0;
        wr_en = 1'b0;
        matrix_index = '0;
        data_set = '0;
        row_data = '0;
        shift = '0;
        sram_wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", 160'(sram_wr_req), 160'(0));
        chk("rst_addr", 160'(sram_addr), 160'(0));
        chk("rst_wdata", 160'(sram_wdata), 160'(0));
        chk("rst_rows", 160'(rows_written), 160'(0));
        chk("rst_ovf", 160'(overflow), 160'(0));
        chk("rst_sat", 160'(sat_flag), 160'(0));
        chk("rst_done", 160'(wb_done), 160'(0));
        tick();
        rst = 1'b0;
        tick();

        // Full 32-row run, shift 0, always ready
        w0 = n_writes;
        start_run();
        for (int r = 0; r < 32; r++)
            send_row(r, 0, 1'b1, 1'b0);
        idle_inputs();
        finish_run();
        wait_done();
        chk("run_writes", 160'(n_writes - w0), 160'(32));
        chk("run_rows", 160'(rows_written), 160'(32));
        chk("run_ovf", 160'(overflow), 160'(0));
        chk("run_sat", 160'(sat_flag), 160'(0));
        chk("run_q_empty", 160'(exp_q.size()), 160'(0));

        // Quantize with shift 4 and saturation
        shift = 5'd4;
        start_run();
        chk("start_clr_rows", 160'(rows_written), 160'(0));
        wr_en = 1'b1;
        data_set = 2'd1;
        matrix_index = 6'd3;
        row_data = '0;
        row_data[0*32 +: 32] = 32'(24);
        row_data[1*32 +: 32] = 32'(-24);
        row_data[2*32 +: 32] = 32'(7);
        row_data[3*32 +: 32] = 32'(100000);
        row_data[4*32 +: 32] = 32'(-100000);
        e.a = 7'd19;
        e.d = '0;
        e.d[7:0]   = 8'h02;
        e.d[15:8]  = 8'hFF;
        e.d[23:16] = 8'h00;
        e.d[31:24] = 8'h7F;
        e.d[39:32] = 8'h80;
        exp_q.push_back(e);
        tick();
        idle_inputs();
        finish_run();
        wait_done();
        chk("quant_sat", 160'(sat_flag), 160'(1));
        chk("quant_rows", 160'(rows_written), 160'(1));
        shift = 5'd0;

        // Backpressure: 8-row burst into a stalled SRAM
        sram_wr_ready = 1'b0;
        w0 = n_writes;
        start_run();
        chk("start_clr_sat", 160'(sat_flag), 160'(0));
        for (int r = 0; r < 8; r++)
            send_row(r, 0, (r < 4), 1'b0);
        idle_inputs();
        repeat (12) tick();
        chk("bp_ovf", 160'(overflow), 160'(1));
        chk("bp_req_held", 160'(sram_wr_req), 160'(1));
        chk("bp_no_write", 160'(n_writes - w0), 160'(0));
        sram_wr_ready = 1'b1;
        finish_run();
        wait_done();
        chk("bp_writes", 160'(n_writes - w0), 160'(4));
        chk("bp_rows", 160'(rows_written), 160'(4));
        chk("bp_q_empty", 160'(exp_q.size()), 160'(0));

        // Full FIFO with push and pop on the same edge
        sram_wr_ready = 1'b0;
        w0 = n_writes;
        start_run();
        chk("start_clr_ovf", 160'(overflow), 160'(0));
        for (int r = 0; r < 5; r++)
            send_row(40 + r, 0, 1'b1, 1'b0);
        idle_inputs();
        sram_wr_ready = 1'b1;
        tick();
        finish_run();
        wait_done();
        chk("pp_writes", 160'(n_writes - w0), 160'(5));
        chk("pp_ovf", 160'(overflow), 160'(0));
        chk("pp_rows", 160'(rows_written), 160'(5));
        chk("pp_q_empty", 160'(exp_q.size()), 160'(0));

        // tpu_done on the same edge as the last row
        w0 = n_writes;
        start_run();
        send_row(20, 0, 1'b1, 1'b0);
        send_row(21, 0, 1'b1, 1'b0);
        send_row(22, 0, 1'b1, 1'b1);
        idle_inputs();
        wait_done();
        chk("co_writes", 160'(n_writes - w0), 160'(3));
        chk("co_done_after_accept", 160'(done_cyc), 160'(acc_cyc + 2));

        // Asynchronous reset mid-drain with 3 rows pending
        sram_wr_ready = 1'b0;
        start_run();
        for (int r = 0; r < 3; r++)
            send_row(10 + r, 0, 1'b1, 1'b0);
        idle_inputs();
        finish_run();
        repeat (3) tick();
        chk("pre_rst_req", 160'(sram_wr_req), 160'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req", 160'(sram_wr_req), 160'(0));
        chk("arst_addr", 160'(sram_addr), 160'(0));
        chk("arst_wdata", 160'(sram_wdata), 160'(0));
        chk("arst_rows", 160'(rows_written), 160'(0));
        chk("arst_done", 160'(wb_done), 160'(0));
        exp_q.delete();
        w0 = n_writes;
        tick();
        rst = 1'b0;
        sram_wr_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_no_write", 160'(n_writes - w0), 160'(0));
        start_run();
        send_row(33, 0, 1'b1, 1'b0);
        send_row(34, 0, 1'b1, 1'b0);
        idle_inputs();
        finish_run();
        wait_done();
        chk("fresh_writes", 160'(n_writes - w0), 160'(2));
        chk("fresh_rows", 160'(rows_written), 160'(2));
        chk("fresh_ovf", 160'(overflow), 160'(0));
        chk("fresh_q_empty", 160'(exp_q.size()), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_writeback.md
# systolic_writeback

Write-back stage directly downstream of the systolic-array controller and array. Each cycle the controller raises its SRAM write enable, this block captures one finished ARRAY_SIZE-wide accumulator row and quantizes it to OUT_WIDTH. It buffers the row in a small FIFO and writes it to the output SRAM through a req/ready port, so a busy SRAM never stalls the array. It reports completion once every captured row has drained.

## Interface
- ARRAY_SIZE, 16, elements per row
- ACC_WIDTH, 32, signed accumulator width per element
- OUT_WIDTH, 8, signed quantized width per element
- FIFO_DEPTH, 4, row entries buffered (power of two)
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- tpu_start  in  1  run start; clears flags and counter
- tpu_done  in  1  controller done pulse
- wr_en  in  1  row valid from controller (its SRAM write enable)
- matrix_index  in  6  row index within data set
- data_set  in  2  data set number
- row_data  in  ARRAY_SIZE*ACC_WIDTH  element i at bits [i*ACC_WIDTH +: ACC_WIDTH]
- shift  in  5  quantization right-shift, static during a run
- sram_wr_req  out  1  write request
- sram_wr_ready  in  1  SRAM accepts this cycle
- sram_addr  out  7  data_set*ARRAY_SIZE + matrix_index, low 7 bits
- sram_wdata  out  ARRAY_SIZE*OUT_WIDTH  quantized row
- rows_written  out  8  rows accepted by SRAM this run
- overflow  out  1  sticky: a row was dropped
- sat_flag  out  1  sticky: an element saturated
- wb_done  out  1  one-cycle completion pulse

## Operation
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE goes to RUN on tpu_start. The same edge clears rows_written, overflow and sat_flag.
- RUN goes to DRAIN on tpu_done.
- DRAIN goes to DONE when the capture stage and the FIFO are both empty.
- DONE asserts wb_done for one cycle, then returns to IDLE.
- Rows are captured in RUN and DRAIN only. wr_en in IDLE or DONE is ignored.
- A tpu_start outside IDLE is ignored.
- Quantization is applied per element as a signed operation:
  - r = (acc + (shift==0 ? 0 : 1<<(shift-1))) >>> shift, computed at ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Any clamped element sets sat_flag.
- Capture stage: one register holding {valid, addr, quantized row}. It pushes into the FIFO on the next edge.
- Push into a full FIFO with no pop on the same edge: the row is dropped, overflow is set, and the FIFO is unchanged.
- Push and pop on the same edge are always legal, including when the FIFO is full; occupancy is unchanged.
- The FIFO head drives sram_wr_req, sram_addr and sram_wdata.
- A pop occurs on an edge where req && ready. rows_written increments on each pop and saturates at 255.

## Timing
- Reset value of every output is 0. FSM goes to IDLE, and the FIFO and capture stage are empty.
- Reset mid-run behaves the same: pending rows are discarded and no write request is issued.
- Latency: wr_en sampled at edge E, pushed at E+1, sram_wr_req high during the cycle after E+1. Minimum latency is 2 cycles.
- With sram_wr_ready held at 1, throughput is 1 row/cycle.
- While req && !ready, sram_wr_req, sram_addr and sram_wdata hold stable.
- sram_wr_req never drops without an accepted write, except on rst.
- tpu_done arriving on the same edge as the last wr_en: that row is still captured and written before wb_done.
- wb_done is high exactly one cycle after the last accepted write, at the earliest.

## Structure
- Package systolic_pkg holds:
  - ARRAY_SIZE, ACC_WIDTH, OUT_WIDTH defaults
  - the FSM state encoding (IDLE/RUN/DRAIN/DONE)
  - the SRAM address width (7)
- Sub-module wb_row_fifo: a parameterized synchronous FIFO with width and depth parameters. It has push, pop, full, empty and a combinational head output.
- Quantize logic is a generate loop over ARRAY_SIZE elements inside this block.

## Test plan
- Full run, 32 rows, data_set 0..1, matrix_index 0..15, ready=1, shift=0, in-range values. Required: 32 writes in order, sram_addr 0..31, rows_written=32, wb_done pulse, overflow=0, sat_flag=0.
- Quantize: shift=4, elements 24, -24, 7, 100000, -100000. Required outputs 2, -1, 0, 127, -128 (arithmetic shift with round-half-up), and sat_flag=1.
- Backpressure: ready low for 20 cycles during a burst of 8 rows. Required: at most 5 rows held (capture stage plus 4 FIFO entries), the rest dropped with overflow=1, and no request change while stalled.
- Full FIFO with simultaneous push/pop, ready released on the edge a new row arrives. Required: no drop, order preserved, overflow stays 0.
- tpu_done coincident with the last wr_en. Required: that row written, then wb_done exactly one cycle after its acceptance.
- rst asserted mid-drain with 3 rows pending. Required: all outputs 0 immediately (asynchronous), no further writes, and the next tpu_start run behaves like a fresh run.
